// File: rtl/receptor_morse_if.sv
// Key-line sampling, pattern table and result signals for the Morse receiver.
// The driver side is the master; the receiver block is the slave.
interface receptor_morse_if #(
    parameter int N_PATRONES = 12,
    parameter int ANCHO      = 22
);
    logic                        tick;
    logic                        linea;
    logic [N_PATRONES*ANCHO-1:0] patrones;
    logic [3:0]                  codigo;
    logic                        valido;
    logic                        error;
    logic                        ocupado;

    modport master (
        output tick, linea, patrones,
        input  codigo, valido, error, ocupado
    );

    modport slave (
        input  tick, linea, patrones,
        output codigo, valido, error, ocupado
    );
endinterface

// File: rtl/receptor_morse.sv
// Serial Morse receiver: captures one character's on/off units per tick and
// reports the lowest-index matching entry of the pattern table.
module receptor_morse #(
    parameter int N_PATRONES = 12,
    parameter int ANCHO      = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    receptor_morse_if.slave   bus
);
    localparam logic [1:0] ESPERA   = 2'd0;
    localparam logic [1:0] CAPTURA  = 2'd1;
    localparam logic [1:0] COMPARA  = 2'd2;
    localparam logic [1:0] DESCARTE = 2'd3;

    localparam logic [ANCHO-1:0] PRIMER_BIT = {1'b1, {(ANCHO-1){1'b0}}};
    localparam logic [4:0]       MAX_BITS   = 5'(ANCHO);

    logic [1:0]       state;
    logic             linea_m;
    logic             linea_s;
    logic [ANCHO-1:0] captura;
    logic [4:0]       n_bits;
    logic [1:0]       ceros;
    logic [3:0]       codigo;
    logic             valido;
    logic             error;
    logic [3:0]       coincide;

    assign bus.codigo  = codigo;
    assign bus.valido  = valido;
    assign bus.error   = error;
    assign bus.ocupado = (state != ESPERA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            linea_m <= 1'b0;
            linea_s <= 1'b0;
        end else begin
            linea_m <= bus.linea;
            linea_s <= linea_m;
        end
    end

    // Scanning upward and keeping the first hit gives lowest-index priority.
    always_comb begin
        coincide = '0;
        for (int unsigned k = 0; k < N_PATRONES; k++) begin
            if (coincide == '0 && bus.patrones[k*ANCHO +: ANCHO] == captura)
                coincide = 4'(k + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ESPERA;
            captura <= '0;
            n_bits  <= '0;
            ceros   <= '0;
            codigo  <= '0;
            valido  <= 1'b0;
            error   <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (state)
                ESPERA: begin
                    if (bus.tick && linea_s) begin
                        captura <= PRIMER_BIT;
                        n_bits  <= 5'd1;
                        ceros   <= '0;
                        state   <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    if (bus.tick) begin
                        if (linea_s) begin
                            ceros <= '0;
                            if (n_bits < MAX_BITS) begin
                                captura <= captura | (PRIMER_BIT >> n_bits);
                                n_bits  <= n_bits + 5'd1;
                            end else begin
                                state <= DESCARTE;
                            end
                        end else begin
                            ceros <= ceros + 2'd1;
                            if (n_bits < MAX_BITS)
                                n_bits <= n_bits + 5'd1;
                            if (ceros == 2'd2)
                                state <= COMPARA;
                        end
                    end
                end
                COMPARA: begin
                    codigo  <= coincide;
                    error   <= 1'b0;
                    valido  <= 1'b1;
                    captura <= '0;
                    n_bits  <= '0;
                    ceros   <= '0;
                    state   <= ESPERA;
                end
                default: begin
                    if (bus.tick) begin
                        if (linea_s) begin
                            ceros <= '0;
                        end else if (ceros == 2'd2) begin
                            ceros  <= '0;
                            codigo <= '0;
                            error  <= 1'b1;
                            valido <= 1'b1;
                            state  <= ESPERA;
                        end else begin
                            ceros <= ceros + 2'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
